// File: rtl/load_store_unit.sv
// load_store_unit: CPU load/store sequencer for a registered-read data_memory.
// Ports: clk, reset (async high); req_* CPU request, resp_* completion,
//   fault; mem_* strobes, address and data wired straight to data_memory.
// Param BIG_ENDIAN selects byte-lane order within a dword.
// Macro LSU_MISALIGN_TRAP_EN: misaligned requests return fault=1 without
//   touching memory; otherwise addresses are force-aligned.
module load_store_unit #(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        fault,
   output logic [63:0] mem_address,
   output logic [63:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [63:0] mem_read_data
);

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE, READ, CAPT, WRITE, RESP
   } state_t;

   state_t      state;
   logic        wr_q;
   logic        sgn_q;
   logic [1:0]  size_q;
   logic [2:0]  off_q;
   logic [63:0] wdata_q;

   logic [2:0]  low_bits;
   logic        misalign;
   logic [2:0]  req_off;
   logic [3:0]  nbytes;
   logic [63:0] byte_mask;
   logic [2:0]  lane_sh;
   logic [5:0]  bit_sh;
   logic [63:0] lane_data;
   logic [63:0] load_ext;
   logic [63:0] merged;

   assign req_ready = (state == IDLE);

   // Offset bits that must be zero for a naturally aligned access.
   always_comb begin
      low_bits = 3'b111;
      unique case (req_size)
         2'b00:   low_bits = 3'b000;
         2'b01:   low_bits = 3'b001;
         2'b10:   low_bits = 3'b011;
         default: low_bits = 3'b111;
      endcase
   end

   assign misalign = |(req_addr[2:0] & low_bits);
   assign req_off  = req_addr[2:0] & ~low_bits;

   always_comb begin
      nbytes    = 4'd8;
      byte_mask = '1;
      unique case (size_q)
         2'b00: begin
            nbytes    = 4'd1;
            byte_mask = 64'h0000_0000_0000_00FF;
         end
         2'b01: begin
            nbytes    = 4'd2;
            byte_mask = 64'h0000_0000_0000_FFFF;
         end
         2'b10: begin
            nbytes    = 4'd4;
            byte_mask = 64'h0000_0000_FFFF_FFFF;
         end
         default: begin
            nbytes    = 4'd8;
            byte_mask = '1;
         end
      endcase
   end

   // Big-endian puts the value's MSB at the lowest address, so the
   // value still occupies contiguous lanes starting at lane 8-off-n.
   assign lane_sh = BIG_ENDIAN ? 3'(4'd8 - {1'b0, off_q} - nbytes)
                               : off_q;
   assign bit_sh    = {lane_sh, 3'b000};
   assign lane_data = mem_read_data >> bit_sh;

   always_comb begin
      load_ext = lane_data;
      unique case (size_q)
         2'b00: load_ext = {{56{sgn_q & lane_data[7]}},  lane_data[7:0]};
         2'b01: load_ext = {{48{sgn_q & lane_data[15]}}, lane_data[15:0]};
         2'b10: load_ext = {{32{sgn_q & lane_data[31]}}, lane_data[31:0]};
         default: load_ext = lane_data;
      endcase
   end

   assign merged = (mem_read_data & ~(byte_mask << bit_sh))
                 | ((wdata_q & byte_mask) << bit_sh);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         wr_q           <= 1'b0;
         sgn_q          <= 1'b0;
         size_q         <= 2'b00;
         off_q          <= 3'b000;
         wdata_q        <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         resp_valid     <= 1'b0;
         resp_rdata     <= '0;
         fault          <= 1'b0;
      end else begin
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         resp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  wr_q    <= req_write;
                  sgn_q   <= req_signed;
                  size_q  <= req_size;
                  off_q   <= req_off;
                  wdata_q <= req_wdata;
                  if (TRAP_EN && misalign) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     fault      <= 1'b1;
                  end else begin
                     mem_address <= {req_addr[63:3], 3'b000};
                     if (req_write && req_size == 2'b11) begin
                        state          <= WRITE;
                        mem_write      <= 1'b1;
                        mem_write_data <= req_wdata;
                     end else begin
                        state    <= READ;
                        mem_read <= 1'b1;
                     end
                  end
               end
            end
            READ: state <= CAPT;
            CAPT: begin
               if (wr_q) begin
                  state          <= WRITE;
                  mem_write      <= 1'b1;
                  mem_write_data <= merged;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= load_ext;
                  fault      <= 1'b0;
               end
            end
            WRITE: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_rdata <= '0;
               fault      <= 1'b0;
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a
// byte-array reference model and a registered-read data_memory stand-in.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        fault;
   logic [63:0] mem_address;
   logic [63:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_read_data;

   always #5 clk = ~clk;

   load_store_unit #(.BIG_ENDIAN(1'b0)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_read_data(mem_read_data)
   );

   // data_memory stand-in: registered read, synchronous write.
   logic [63:0] dmem [0:63];
   always @(posedge clk) begin
      if (mem_read)  mem_read_data <= dmem[mem_address[8:3]];
      if (mem_write) dmem[mem_address[8:3]] = mem_write_data;
   end

   // Reference model: plain byte-addressed memory, little-endian.
   logic [7:0] refm [0:511];

   int total = 0;
   int bad   = 0;

   logic        active = 1'b0;
   logic        done   = 1'b0;
   int          cyc, nrd, nwr;
   int          e_lat, e_nrd, e_nwr;
   logic [63:0] e_rdata, e_addr;
   logic        e_fault;
   logic [63:0] last_rdata = '0;
   logic        last_fault = 1'b0;
   logic [63:0] act_rdata;
   logic        act_fault;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_dword(input int a);
      logic [63:0] v;
      for (int k = 0; k < 8; k++) v[8*k +: 8] = refm[a + k];
      return v;
   endfunction

   task automatic preload(input int a, input logic [63:0] d);
      dmem[a[8:3]] = d;
      for (int k = 0; k < 8; k++) refm[a + k] = d[8*k +: 8];
   endtask

   // Per-cycle compare against the expectations of the open request.
   always @(negedge clk) begin
      if (reset) begin
         active = 1'b0;
      end else if (active) begin
         cyc++;
         check("busy_ready", {63'd0, req_ready}, 64'd0);
         if (mem_read) begin
            nrd++;
            check("rd_addr", mem_address, e_addr);
         end
         if (mem_write) begin
            nwr++;
            check("wr_addr", mem_address, e_addr);
         end
         if (resp_valid) begin
            check("latency", 64'(cyc), 64'(e_lat));
            check("rdata", resp_rdata, e_rdata);
            check("fault", {63'd0, fault}, {63'd0, e_fault});
            check("n_read", 64'(nrd), 64'(e_nrd));
            check("n_write", 64'(nwr), 64'(e_nwr));
            act_rdata  = resp_rdata;
            act_fault  = fault;
            last_rdata = e_rdata;
            last_fault = e_fault;
            active = 1'b0;
            done   = 1'b1;
         end
      end else begin
         check("idle_resp", {63'd0, resp_valid}, 64'd0);
         check("idle_strobe", {62'd0, mem_read, mem_write}, 64'd0);
         check("hold_rdata", resp_rdata, last_rdata);
         check("hold_fault", {63'd0, fault}, {63'd0, last_fault});
      end
   end

   task automatic start_req(input logic wr, input logic [1:0] sz,
                            input logic sg, input int a,
                            input logic [63:0] wd);
      int n;
      int al;
      logic [63:0] v;
      n  = 1 << sz;
      al = a & ~(n - 1);
`ifdef LSU_MISALIGN_TRAP_EN
      if (al != a) begin
         e_lat = 1; e_nrd = 0; e_nwr = 0;
         e_rdata = '0; e_fault = 1'b1;
      end else
`endif
      if (wr) begin
         for (int k = 0; k < n; k++) refm[al + k] = wd[8*k +: 8];
         e_rdata = '0; e_fault = 1'b0;
         e_nrd = (n == 8) ? 0 : 1;
         e_nwr = 1;
         e_lat = (n == 8) ? 2 : 4;
      end else begin
         v = '0;
         for (int k = 0; k < n; k++) v[8*k +: 8] = refm[al + k];
         if (sg && n < 8 && v[8*n - 1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
         e_rdata = v; e_fault = 1'b0;
         e_nrd = 1; e_nwr = 0; e_lat = 3;
      end
      e_addr = 64'(al & ~7);
      @(negedge clk);
      check("ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = 64'(a);
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 0; nrd = 0; nwr = 0;
      done   = 1'b0;
      active = 1'b1;
   endtask

   task automatic wait_resp();
      for (int i = 0; i < 20; i++) begin
         if (done) break;
         @(posedge clk);
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL timeout act=no_resp exp=resp");
         active = 1'b0;
      end
   endtask

   task automatic issue(input logic wr, input logic [1:0] sz,
                        input logic sg, input int a,
                        input logic [63:0] wd);
      start_req(wr, sz, sg, a, wd);
      wait_resp();
   endtask

   logic [63:0] saved;

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 64; i++) dmem[i] = '0;
      for (int i = 0; i < 512; i++) refm[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", {63'd0, req_ready}, 64'd1);
      check("rst_resp", {63'd0, resp_valid}, 64'd0);
      check("rst_rdata", resp_rdata, 64'd0);
      check("rst_fault", {63'd0, fault}, 64'd0);
      check("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      reset = 1'b0;

      preload(32'h10, 64'h8877665544332211);
      issue(1'b0, 2'b00, 1'b0, 32'h13, '0);
      check("lit_byte", act_rdata, 64'h44);

      preload(32'h10, 64'h00000000F0000000);
      issue(1'b0, 2'b10, 1'b1, 32'h10, '0);
      check("lit_word_s", act_rdata, 64'hFFFFFFFFF0000000);
      issue(1'b0, 2'b10, 1'b0, 32'h10, '0);
      check("lit_word_u", act_rdata, 64'h00000000F0000000);

      preload(32'h10, 64'h8877665544332211);
      issue(1'b1, 2'b01, 1'b0, 32'h14, 64'hBEEF);
      check("lit_half_st", dmem[2], 64'h8877BEEF44332211);
      issue(1'b0, 2'b11, 1'b0, 32'h10, '0);

      issue(1'b1, 2'b11, 1'b0, 32'h20, 64'hDEADBEEFCAFEF00D);
      check("lit_dword_st", dmem[4], 64'hDEADBEEFCAFEF00D);
      check("model_dword", dmem[4], ref_dword(32'h20));

      preload(32'h10, 64'h8877665544332211);
      issue(1'b0, 2'b10, 1'b0, 32'h12, '0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("lit_mis_data", act_rdata, 64'd0);
      check("lit_mis_fault", {63'd0, act_fault}, 64'd1);
`else
      check("lit_mis_data", act_rdata, 64'h44332211);
      check("lit_mis_fault", {63'd0, act_fault}, 64'd0);
`endif

      issue(1'b0, 2'b00, 1'b1, 32'h17, '0);
      check("lit_sbyte", act_rdata, 64'hFFFFFFFFFFFFFF88);
      issue(1'b0, 2'b01, 1'b1, 32'h16, '0);
      issue(1'b0, 2'b01, 1'b0, 32'h12, '0);
      issue(1'b1, 2'b00, 1'b0, 32'h21, 64'h1234_5678_9ABC_DE5A);
      issue(1'b1, 2'b10, 1'b1, 32'h24, 64'hFFFF_FFFF_0BAD_F00D);
      issue(1'b1, 2'b01, 1'b0, 32'h23, 64'hA5C3);
      issue(1'b0, 2'b11, 1'b1, 32'h20, '0);
      check("model_mixed", dmem[4], ref_dword(32'h20));

      // Abort a half store while it is in CAPT.
      preload(32'h10, 64'h8877665544332211);
      saved = ref_dword(32'h10);
      start_req(1'b1, 2'b01, 1'b0, 32'h14, 64'hBEEF);
      @(negedge clk);
      @(negedge clk);
      #1;
      reset  = 1'b1;
      active = 1'b0;
      preload(32'h10, saved);
      #1;
      check("abort_resp", {63'd0, resp_valid}, 64'd0);
      check("abort_rdata", resp_rdata, 64'd0);
      check("abort_fault", {63'd0, fault}, 64'd0);
      check("abort_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      check("abort_ready", {63'd0, req_ready}, 64'd1);
      last_rdata = '0;
      last_fault = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_mem", dmem[2], 64'h8877665544332211);
      issue(1'b0, 2'b11, 1'b0, 32'h10, '0);
      check("post_abort", act_rdata, 64'h8877665544332211);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
